exu_wb_arbiter: RTL
===================

EXU_WB_ARBITER -- requirements
Module: exu_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, datapath width of writeback data.
REQ-002 Parameter REG_FILE_ADDR_WIDTH, default 5, register-file address width.
REQ-003 Source index fixed: 0=ALU, 1=MUL, 2=DIV, 3=LSU; NUM_SRC=4, not a parameter.
REQ-004 clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset; asynchronous and active-low.
REQ-006 req_valid  input  4  per-source writeback request, bit i = source i.
REQ-007 req_ready  output  4  per-source acceptance; transfer occurs when req_valid[i] & req_ready[i] at a rising edge.
REQ-008 req_rd_addr  input  4*REG_FILE_ADDR_WIDTH  destination register per source, source i in slice i.
REQ-009 req_data  input  4*XLEN  result data per source, source i in slice i.
REQ-010 exu_wb_data  output  XLEN  registered writeback data to register file.
REQ-011 exu_wb_rd_addr  output  REG_FILE_ADDR_WIDTH  registered writeback address.
REQ-012 exu_wb_rd_wr_en  output  1  registered writeback strobe, one cycle per granted non-x0 entry.
REQ-013 wb_busy  output  1  high when any entry is pending or exu_wb_rd_wr_en is high.

Function
REQ-014 One single-entry holding buffer per source: pend[i], addr[i], data[i].
REQ-015 req_ready[i] = ~pend[i] | grant[i] (combinational; a draining buffer accepts a new entry in the same cycle).
REQ-016 On accepted transfer, buffer i captures req_rd_addr/req_data slice i and sets pend[i]; on grant without new transfer, pend[i] clears.
REQ-017 Grant is combinational from pend only; a request is never granted in the cycle it is accepted.
REQ-018 Round-robin arbitration: 2-bit rr_ptr; grant the first pend[i] scanning i = rr_ptr, rr_ptr+1, ... modulo 4; at most one grant per cycle.
REQ-019 After a grant to source g, rr_ptr <= (g+1) mod 4; with no grant, rr_ptr holds.
REQ-020 On grant, output registers load exu_wb_data=data[g], exu_wb_rd_addr=addr[g], exu_wb_rd_wr_en=(addr[g]!=0).
REQ-021 With no grant, exu_wb_rd_wr_en <= 0; exu_wb_data and exu_wb_rd_addr hold their previous values.
REQ-022 Entries with rd_addr 0 are consumed (buffer drains, rr_ptr advances) but produce no write strobe.
REQ-023 Latency: transfer accepted at edge N on an idle arbiter -> exu_wb_rd_wr_en high in the cycle following edge N+1.
REQ-024 Throughput: one writeback per cycle while any pend[i] is set.
REQ-025 Starvation bound: a pending entry is granted within 4 cycles of pend[i] being set.
REQ-026 Per-source order preserved; cross-source WAW ordering is enforced upstream by issue stall logic, not here.
REQ-027 Simultaneous request from all 4 sources with all buffers empty: all accepted same edge, drained in rr order over the next 4 cycles.
REQ-028 Continuous req_valid[i] on a granted buffer: back-to-back entries accepted every cycle the buffer is granted; req_ready[i] low while pend[i] & ~grant[i].

Reset
REQ-029 rstn low asynchronously clears pend[3:0], rr_ptr=0, exu_wb_rd_wr_en=0, exu_wb_data=0, exu_wb_rd_addr=0.
REQ-030 During reset req_ready reads 4'b1111 (all buffers empty) but no transfer is captured while rstn is low.
REQ-031 Reset asserted mid-operation discards all pending entries; no writeback strobe issues after rstn deassertion until new requests are accepted.

Verification
REQ-032 Single ALU request rd=5, data=0x12345678 at edge 0 -> exu_wb_rd_wr_en=1, addr=5, data=0x12345678 for exactly one cycle after edge 1; wb_busy low after edge 2.
REQ-033 All four sources request at edge 0 with rd=1,2,3,4 and rr_ptr=0 -> strobes for rd 1,2,3,4 on 4 consecutive cycles, rr_ptr ends at 0.
REQ-034 MUL request rd=0, data=0xDEADBEEF -> buffer drains, exu_wb_rd_wr_en stays 0, rr_ptr advances to 2.
REQ-035 ALU req_valid held high for 6 cycles with LSU pending -> grants alternate ALU/LSU; req_ready[0] low on cycles ALU is pending and not granted; no entry lost or duplicated.
REQ-036 rstn pulsed low with 3 entries pending -> outputs zero immediately (asynchronously), no strobe after release, rr_ptr=0.
REQ-037 Scoreboard check across random traffic: every accepted non-x0 entry produces exactly one strobe with matching addr/data, each within 4 cycles of acceptance.

Source files
------------

// File: rtl/exu_wb_arbiter.sv
// Writeback arbiter for the four execution sources (ALU, MUL, DIV, LSU).
// Each source owns a single-entry holding buffer. A round-robin pointer picks
// one pending buffer per cycle, and that entry is registered onto the
// register-file write port. Entries that target x0 drain without a strobe.
module exu_wb_arbiter #(
    parameter int XLEN                = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [3:0]                         req_valid,
    output logic [3:0]                         req_ready,
    input  logic [4*REG_FILE_ADDR_WIDTH-1:0]   req_rd_addr,
    input  logic [4*XLEN-1:0]                  req_data,
    output logic [XLEN-1:0]                    exu_wb_data,
    output logic [REG_FILE_ADDR_WIDTH-1:0]     exu_wb_rd_addr,
    output logic                               exu_wb_rd_wr_en,
    output logic                               wb_busy
);

    localparam int NUM_SRC = 4;

    logic [NUM_SRC-1:0]             r_pend;
    logic [REG_FILE_ADDR_WIDTH-1:0] r_addr [NUM_SRC];
    logic [XLEN-1:0]                r_data [NUM_SRC];
    logic [1:0]                     r_rrPtr;

    logic [XLEN-1:0]                r_wbData;
    logic [REG_FILE_ADDR_WIDTH-1:0] r_wbAddr;
    logic                           r_wbWrEn;

    logic [NUM_SRC-1:0]             w_grant;
    logic [1:0]                     w_grantIdx;
    logic                           w_anyGrant;
    logic [1:0]                     w_scanIdx;
    logic [NUM_SRC-1:0]             w_accept;

    // Round-robin pick: first pending buffer starting at the pointer, wrapping mod 4
    always_comb begin
        w_grant    = '0;
        w_grantIdx = r_rrPtr;
        w_anyGrant = 1'b0;
        w_scanIdx  = r_rrPtr;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_scanIdx = r_rrPtr + 2'(k);
            if (!w_anyGrant && r_pend[w_scanIdx]) begin
                w_anyGrant           = 1'b1;
                w_grantIdx           = w_scanIdx;
                w_grant[w_scanIdx]   = 1'b1;
            end
        end
    end

    // A buffer can take a new entry when empty or when it is being drained this cycle
    always_comb begin
        req_ready = ~r_pend | w_grant;
        w_accept  = req_valid & req_ready;
    end

    // Holding buffers: capture on transfer, clear when granted with nothing new arriving
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_accept[i]) begin
                    r_pend[i] <= 1'b1;
                    r_addr[i] <= req_rd_addr[i*REG_FILE_ADDR_WIDTH +: REG_FILE_ADDR_WIDTH];
                    r_data[i] <= req_data[i*XLEN +: XLEN];
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Pointer moves just past the winner so every source gets a turn within four cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rrPtr <= 2'd0;
        end else if (w_anyGrant) begin
            r_rrPtr <= w_grantIdx + 2'd1;
        end
    end

    // Register the winner onto the write port; x0 targets are consumed silently
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wbData <= '0;
            r_wbAddr <= '0;
            r_wbWrEn <= 1'b0;
        end else if (w_anyGrant) begin
            r_wbData <= r_data[w_grantIdx];
            r_wbAddr <= r_addr[w_grantIdx];
            r_wbWrEn <= (r_addr[w_grantIdx] != '0);
        end else begin
            r_wbWrEn <= 1'b0;
        end
    end

    assign exu_wb_data     = r_wbData;
    assign exu_wb_rd_addr  = r_wbAddr;
    assign exu_wb_rd_wr_en = r_wbWrEn;
    assign wb_busy         = (|r_pend) | r_wbWrEn;

endmodule
